// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, the NOP bubble word, PC step.
package fetch_stage_pkg;

  // ST_LOCK is entered only when FETCH_MISALIGN_CHK_EN is defined.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2,
    ST_LOCK  = 2'd3
  } fetch_st_e;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;  // addi x0,x0,0
  localparam int          PC_INC  = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. clr loads a bubble and beats en.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  d_misal,
  input  logic [DATA_WIDTH-1:0] d_ins,
  input  logic [DATA_WIDTH-1:0] d_pc,
  input  logic [DATA_WIDTH-1:0] d_pc4,
  output logic                  q_vld,
  output logic                  q_misal,
  output logic [DATA_WIDTH-1:0] q_ins,
  output logic [DATA_WIDTH-1:0] q_pc,
  output logic [DATA_WIDTH-1:0] q_pc4
);

  // Bubble on reset/clear, otherwise load a real entry when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_vld   <= 1'b0;
      q_misal <= 1'b0;
      q_ins   <= DATA_WIDTH'(NOP_INS);
      q_pc    <= '0;
      q_pc4   <= '0;
    end else if (en) begin
      q_vld   <= 1'b1;
      q_misal <= d_misal;
      q_ins   <= d_ins;
      q_pc    <= d_pc;
      q_pc4   <= d_pc4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake FSM (FETCH/HOLD/DROP), IF/ID.
// Optional: FETCH_MISALIGN_CHK_EN traps misaligned redirect targets.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  pc_src_e,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] ins,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus_4d,
  output logic                  valid_d,
  output logic                  misalign_d
);

  fetch_st_e             st, st_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt, pc_inc, hold_ins, word_ins;
  logic                  word_vld, hold_ld;

  assign pc_inc = pc + DATA_WIDTH'(PC_INC);  // wraps mod 2^DATA_WIDTH

`ifdef FETCH_MISALIGN_CHK_EN
  logic redir_bad, word_misal, owe, owe_nxt;
  assign redir_bad = pc_src_e && (pc_target_e[1:0] != 2'b00);
`endif

  // Next state, next PC and the word offered to IF/ID this cycle.
  always_comb begin
    st_nxt   = st;
    pc_nxt   = pc;
    word_vld = 1'b0;
    word_ins = imem.imem_rdata;
    hold_ld  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    word_misal = 1'b0;
    owe_nxt    = owe;
`endif
    case (st)
      ST_FETCH: begin
        if (imem.imem_ack) begin
          // A redirect in the ack cycle throws the response away.
          if (!pc_src_e) begin
            if (!stall_d) begin
              word_vld = 1'b1;
              pc_nxt   = pc_inc;
            end else begin
              hold_ld = 1'b1;
              st_nxt  = ST_HOLD;
            end
          end
        end else if (pc_src_e) begin
          st_nxt = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (pc_src_e) begin
          st_nxt = ST_FETCH;
        end else if (!stall_d) begin
          word_vld = 1'b1;
          word_ins = hold_ins;
          pc_nxt   = pc_inc;
          st_nxt   = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem.imem_ack) st_nxt = ST_FETCH;
      end
      default: begin
`ifdef FETCH_MISALIGN_CHK_EN
        // Trap entry: valid slot, bubble word, misalign flag set.
        word_vld   = 1'b1;
        word_ins   = DATA_WIDTH'(NOP_INS);
        word_misal = 1'b1;
`endif
      end
    endcase
    if (pc_src_e) pc_nxt = pc_target_e;
`ifdef FETCH_MISALIGN_CHK_EN
    // owe remembers a response still in flight while locked, so leaving
    // the lock goes through DROP instead of mistaking it for a new word.
    if (st == ST_LOCK) begin
      owe_nxt = owe && !imem.imem_ack;
      if (pc_src_e) st_nxt = owe_nxt ? ST_DROP : ST_FETCH;
    end
    if (redir_bad) begin
      st_nxt  = ST_LOCK;
      owe_nxt = !imem.imem_ack &&
                ((st == ST_FETCH) || (st == ST_DROP) || ((st == ST_LOCK) && owe));
    end
`endif
  end

  // State, PC and hold buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_FETCH;
      pc       <= RESET_PC;
      hold_ins <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      owe      <= 1'b0;
`endif
    end else begin
      st <= st_nxt;
      pc <= pc_nxt;
      if (hold_ld) hold_ins <= imem.imem_rdata;
`ifdef FETCH_MISALIGN_CHK_EN
      owe <= owe_nxt;
`endif
    end
  end

  // The request stays up in DROP until the stale response is absorbed.
  assign imem.imem_req  = !rst && ((st == ST_FETCH) || (st == ST_DROP));
  assign imem.imem_addr = pc;

  if_id_reg #(.DATA_WIDTH(DATA_WIDTH)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .en      (!stall_d),
    .clr     (flush_d || (!stall_d && !word_vld)),
`ifdef FETCH_MISALIGN_CHK_EN
    .d_misal (word_misal),
`else
    .d_misal (1'b0),  // misalign_d is constant zero in this build
`endif
    .d_ins   (word_ins),
    .d_pc    (pc),
    .d_pc4   (pc_inc),
    .q_vld   (valid_d),
    .q_misal (misalign_d),
    .q_ins   (ins),
    .q_pc    (pc_d),
    .q_pc4   (pc_plus_4d)
  );

endmodule
